output_dense_stage: RTL and testbench

- Single-neuron fully-connected output stage, directly downstream of the LSTM `network` block.
- Captures the hidden vector `outputVec` when the layer signals completion, then computes the dot product with the output weight vector plus a bias, one MAC per cycle.
- Saturates the result to Q(QN).(QM) and emits a one-cycle `outValid` pulse.
- Replaces the bench-driven enable/reset sequencing of the previous perceptron with a self-contained handshake.

---
 rtl/output_dense_stage_pkg.sv | 32 +++
 rtl/output_dense_stage_fx_mac.sv | 32 +++
 rtl/output_dense_stage.sv | 107 ++++++++++
 tb/tb_output_dense_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/output_dense_stage_pkg.sv
// Shared fixed-point constants, FSM encoding and saturation helper for the dense output stage.
package output_dense_stage_pkg;

   localparam int QN       = 6;
   localparam int QM       = 11;
   localparam int BITWIDTH = QN + QM + 1;
   localparam int SAT_W    = 64;

   localparam longint SAT_MAX = (64'sd1 <<< (BITWIDTH - 1)) - 64'sd1;
   localparam longint SAT_MIN = -(64'sd1 <<< (BITWIDTH - 1));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Input must already be scaled back to Q(QN).(QM) and sign-extended to SAT_W.
   function automatic logic signed [BITWIDTH-1:0] sat_to_bitwidth(input logic signed [SAT_W-1:0] v);
      if (v > SAT_MAX) return BITWIDTH'(SAT_MAX);
      if (v < SAT_MIN) return BITWIDTH'(SAT_MIN);
      return v[BITWIDTH-1:0];
   endfunction

endpackage

// File: rtl/output_dense_stage_fx_mac.sv
// Registered signed multiply-accumulate with synchronous load; load wins over accumulate.
module fx_mac #(
   parameter int IN_W  = 18,
   parameter int ACC_W = 40
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    i_load,
   input  logic signed [ACC_W-1:0] i_load_val,
   input  logic                    i_en,
   input  logic signed [IN_W-1:0]  i_a,
   input  logic signed [IN_W-1:0]  i_b,
   output logic signed [ACC_W-1:0] o_acc
);

   logic signed [2*IN_W-1:0] w_prod;
   logic signed [ACC_W-1:0]  r_acc;

   assign w_prod = i_a * i_b;
   assign o_acc  = r_acc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_acc <= '0;
      end else if (i_load) begin
         r_acc <= i_load_val;
      end else if (i_en) begin
         r_acc <= r_acc + ACC_W'(w_prod);
      end
   end

endmodule

// File: rtl/output_dense_stage.sv
// Single-neuron dense output: captures the hidden vector on start, one MAC per cycle,
// then saturates to Q(QN).(QM) and strobes outValid; start while busy is dropped.
module output_dense_stage
   import output_dense_stage_pkg::*;
#(
   parameter  int HIDDEN_SZ      = 8,
   localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [LAYER_BITWIDTH-1:0]  hiddenVec,
   input  logic [LAYER_BITWIDTH-1:0]  weightVec,
   input  logic signed [BITWIDTH-1:0] bias,
   output logic                       busy,
   output logic                       outValid,
   output logic signed [BITWIDTH-1:0] outData
);

   localparam int IDX_W        = clog2(HIDDEN_SZ);
   localparam int ACC_BITWIDTH = 2 * BITWIDTH + IDX_W + 1;

   state_t                     r_state;
   state_t                     w_next;
   logic [IDX_W-1:0]           r_idx;
   logic [LAYER_BITWIDTH-1:0]  r_hid;
   logic                       r_vld;
   logic signed [BITWIDTH-1:0] r_out;

   logic                           w_load;
   logic                           w_mac_en;
   logic                           w_emit;
   logic signed [BITWIDTH-1:0]     w_h;
   logic signed [BITWIDTH-1:0]     w_w;
   logic signed [ACC_BITWIDTH-1:0] w_bias_ext;
   logic signed [ACC_BITWIDTH-1:0] w_acc;
   logic signed [ACC_BITWIDTH-1:0] w_acc_shr;

   always_comb begin
      w_next   = r_state;
      w_load   = 1'b0;
      w_mac_en = 1'b0;
      w_emit   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load = 1'b1;
               w_next = MAC;
            end
         end
         MAC: begin
            w_mac_en = 1'b1;
            if (r_idx == IDX_W'(HIDDEN_SZ - 1)) w_next = OUT;
         end
         OUT: begin
            w_emit = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_h        = r_hid[r_idx*BITWIDTH +: BITWIDTH];
   assign w_w        = weightVec[r_idx*BITWIDTH +: BITWIDTH];
   // Bias is pre-scaled so the accumulator stays in Q(2*QM) alongside the products.
   assign w_bias_ext = ACC_BITWIDTH'(bias) <<< QM;
   assign w_acc_shr  = w_acc >>> QM;

   fx_mac #(
      .IN_W  (BITWIDTH),
      .ACC_W (ACC_BITWIDTH)
   ) u_mac (
      .clock      (clock),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_val (w_bias_ext),
      .i_en       (w_mac_en),
      .i_a        (w_h),
      .i_b        (w_w),
      .o_acc      (w_acc)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_hid   <= '0;
         r_vld   <= 1'b0;
         r_out   <= '0;
      end else begin
         r_state <= w_next;
         r_vld   <= w_emit;
         if (w_load) begin
            r_hid <= hiddenVec;
            r_idx <= '0;
         end else if (w_mac_en) begin
            r_idx <= r_idx + IDX_W'(1);
         end
         if (w_emit) r_out <= sat_to_bitwidth(SAT_W'(w_acc_shr));
      end
   end

   assign busy     = (r_state != IDLE);
   assign outValid = r_vld;
   assign outData  = r_out;

endmodule

// File: tb/tb_output_dense_stage.sv
// Randomized scoreboard bench for output_dense_stage against a plain-arithmetic dot-product model.
module tb_output_dense_stage;

   localparam int HS = 8;
   localparam int BW = 18;
   localparam int LW = HS * BW;

   logic                 clock;
   logic                 reset;
   logic                 start;
   logic [LW-1:0]        hiddenVec;
   logic [LW-1:0]        weightVec;
   logic signed [BW-1:0] bias;
   logic                 busy;
   logic                 outValid;
   logic signed [BW-1:0] outData;

   output_dense_stage #(.HIDDEN_SZ(HS)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .hiddenVec (hiddenVec),
      .weightVec (weightVec),
      .bias      (bias),
      .busy      (busy),
      .outValid  (outValid),
      .outData   (outData)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [BW-1:0] data;
      int            cyc;
   } exp_t;

   exp_t q[$];
   int   n_cmp   = 0;
   int   n_fail  = 0;
   int   free_at = 0;
   int   th[HS];
   int   tw[HS];
   int   tb_bias;

   task automatic chk(input string name, input longint got, input longint want);
      n_cmp++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, want, want);
      end
   endtask

   function automatic logic [LW-1:0] pack(input int a[HS]);
      logic [LW-1:0] r;
      r = '0;
      for (int i = 0; i < HS; i++) r[i*BW +: BW] = a[i][BW-1:0];
      return r;
   endfunction

   // Reference: bias + sum(h*w)/2^11 floored, clamped to the signed 18-bit range.
   function automatic logic [BW-1:0] ref_out();
      longint        s;
      logic [BW-1:0] r;
      s = longint'(tb_bias) * 2048;
      for (int i = 0; i < HS; i++) s += longint'(th[i]) * longint'(tw[i]);
      s = s >>> 11;
      if (s > 131071) s = 131071;
      else if (s < -131072) s = -131072;
      r = s[BW-1:0];
      return r;
   endfunction

   function automatic int rnd(input int r);
      return int'($urandom_range(0, 2*r - 1)) - r;
   endfunction

   // Called at a negedge; the request is accepted only if the model says the stage is idle.
   task automatic issue(input bit wait_free);
      exp_t e;
      if (wait_free) begin
         int k = 0;
         while (cyc + 1 < free_at && k < 100) begin
            @(negedge clock);
            k++;
         end
      end
      hiddenVec = pack(th);
      weightVec = pack(tw);
      bias      = tb_bias[BW-1:0];
      start     = 1'b1;
      if (cyc + 1 >= free_at) begin
         e.data  = ref_out();
         e.cyc   = cyc + HS + 2;
         q.push_back(e);
         free_at = cyc + 1 + HS + 2;
      end
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int k = 0;
      while ((q.size() != 0 || busy) && k < 200) begin
         @(negedge clock);
         k++;
      end
      if (k >= 200) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_done: timed out with %0d results outstanding, busy=%0b", q.size(), busy);
      end
   endtask

   task automatic fill(input int hv, input int wv);
      for (int i = 0; i < HS; i++) begin
         th[i] = hv;
         tw[i] = wv;
      end
   endtask

   // Monitor: every outValid must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && outValid) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_outValid: got outValid=1 data=0x%0h at cycle %0d, required no pulse", outData, cyc);
            end else begin
               e = q.pop_front();
               chk("outData", longint'(outData[BW-1:0]), longint'(e.data));
               chk("outValid_cycle", cyc, e.cyc);
               chk("busy_with_outValid", busy, 0);
            end
         end
      end
   end

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      hiddenVec = '0;
      weightVec = '0;
      bias      = '0;
      tb_bias   = 0;
      fill(0, 0);
      repeat (2) @(negedge clock);
      chk("reset_busy", busy, 0);
      chk("reset_outValid", outValid, 0);
      chk("reset_outData", longint'(outData[BW-1:0]), 0);
      reset = 1'b0;
      @(negedge clock);

      // 1.0 * 0.5 over eight elements
      fill(2048, 1024);
      tb_bias = 0;
      issue(1);
      wait_done();

      // -1.0 * one LSB floors to -1 LSB
      fill(0, 0);
      th[0] = -2048;
      tw[0] = 1;
      issue(1);
      wait_done();

      fill(63488, 63488);
      issue(1);
      wait_done();
      fill(63488, -63488);
      issue(1);
      wait_done();

      // bias only, then back-to-back start on the outValid cycle
      fill(2048, 0);
      tb_bias = 2048;
      issue(1);
      fill(2048, 2048);
      issue(1);
      wait_done();

      // start during MAC with a different vector is dropped
      fill(1000, -700);
      tb_bias = 100;
      issue(1);
      repeat (2) @(negedge clock);
      for (int i = 0; i < HS; i++) th[i] = -3000 + i;
      issue(0);
      wait_done();

      // reset 4 cycles into MAC abandons the operation
      fill(1500, 1500);
      tb_bias = 0;
      issue(1);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      #1;
      chk("midreset_busy", busy, 0);
      chk("midreset_outData", longint'(outData[BW-1:0]), 0);
      chk("midreset_outValid", outValid, 0);
      q.delete();
      free_at = 0;
      @(negedge clock);
      reset = 1'b0;
      repeat (14) @(negedge clock);
      fill(-2048, 3072);
      tb_bias = -512;
      issue(1);
      wait_done();

      for (int n = 0; n < 24; n++) begin
         int r;
         r = ($urandom_range(0, 3) == 0) ? 131072 : 4096;
         for (int i = 0; i < HS; i++) begin
            th[i] = rnd(r);
            tw[i] = rnd(r);
         end
         tb_bias = rnd(65536);
         issue(1);
         if (n % 5 == 0) begin
            repeat (2) @(negedge clock);
            for (int i = 0; i < HS; i++) th[i] = rnd(131072);
            issue(0);
         end
         repeat ($urandom_range(0, 12)) @(negedge clock);
      end
      wait_done();
      repeat (5) @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
